calculate_exp_table: RTL and testbench

- Parametrised successor to the single-sigma exponent generator in the risk-calculation datapath.
- Fills a coefficient RAM with a geometric sequence: entry k = iSeed * iRatio^k, in unsigned fixed point. The caller supplies iRatio as exp(sigma*dt), precomputed.
- Generalised over data width, fraction width, table depth and run length. Adds a downstream ready handshake, rounding, saturation and a sticky overflow flag.

---
 rtl/calculate_exp_table.sv | 121 ++++++++++++
 tb/tb_calculate_exp_table.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/calculate_exp_table.sv
// Geometric coefficient table generator: entry k = seed * ratio^k in UQ fixed point,
// streamed with a valid/ready handshake, round-half-up and saturating arithmetic.
module calculate_exp_table #(
    parameter int DATA_W = 18,
    parameter int FRAC_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iSeed,
    input  logic [DATA_W-1:0] iRatio,
    input  logic [ADDR_W-1:0] iLast,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oValid,
    output logic              oBusy,
    output logic              oDone,
    output logic              oSat
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t state, nextState;

    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] ratio;
    logic [ADDR_W-1:0] last;

    logic [PW-1:0]     prod;
    logic [PW-1:0]     biased;
    logic [PW-1:0]     shifted;
    logic              nextSat;
    logic [DATA_W-1:0] nextData;
    logic              accept;
    logic              atLast;

    assign accept = oValid && iReady;
    assign atLast = (oAddr == last);

    // Product cannot overflow PW bits even with the rounding bias added.
    always_comb begin
        prod     = PW'(oData) * PW'(ratio);
        biased   = prod + (PW'(1) << (FRAC_W - 1));
        shifted  = biased >> FRAC_W;
        nextSat  = |shifted[PW-1:DATA_W];
        nextData = nextSat ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iStart) nextState = LOAD;
            LOAD:    nextState = RUN;
            RUN:     if (accept && atLast) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        oDone = (state == FIN);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seed   <= '0;
            ratio  <= '0;
            last   <= '0;
            oData  <= '0;
            oAddr  <= '0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            oSat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        seed  <= iSeed;
                        ratio <= iRatio;
                        last  <= iLast;
                        oSat  <= 1'b0;
                        oBusy <= 1'b1;
                    end
                end
                LOAD: begin
                    oData  <= seed;
                    oAddr  <= '0;
                    oValid <= 1'b1;
                end
                RUN: begin
                    if (accept) begin
                        if (atLast) begin
                            oValid <= 1'b0;
                        end else begin
                            oAddr <= oAddr + ADDR_W'(1);
                            oData <= nextData;
                            if (nextSat) oSat <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    oBusy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calculate_exp_table.sv
// Directed bench for calculate_exp_table: fixed-point sequences, stalls,
// ignored restarts, saturation stickiness and asynchronous abort.
module tb_calculate_exp_table;

    localparam int DATA_W = 18;
    localparam int FRAC_W = 12;
    localparam int ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iStart;
    logic [DATA_W-1:0] iSeed;
    logic [DATA_W-1:0] iRatio;
    logic [ADDR_W-1:0] iLast;
    logic              iReady;
    logic [DATA_W-1:0] oData;
    logic [ADDR_W-1:0] oAddr;
    logic              oValid;
    logic              oBusy;
    logic              oDone;
    logic              oSat;

    int nChecks = 0;
    int nFails  = 0;
    int expV[$];

    calculate_exp_table #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .iStart(iStart),
        .iSeed(iSeed),
        .iRatio(iRatio),
        .iLast(iLast),
        .iReady(iReady),
        .oData(oData),
        .oAddr(oAddr),
        .oValid(oValid),
        .oBusy(oBusy),
        .oDone(oDone),
        .oSat(oSat)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint got, input longint exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, " valid"}, longint'(oValid), 0);
        check({tag, " data"},  longint'(oData), 0);
        check({tag, " addr"},  longint'(oAddr), 0);
        check({tag, " busy"},  longint'(oBusy), 0);
        check({tag, " done"},  longint'(oDone), 0);
        check({tag, " sat"},   longint'(oSat), 0);
    endtask

    task automatic runCase(input string nm, input int seed, input int ratio,
                           input int last, input logic [31:0] pat,
                           input int satFrom, input bit poke, input int rstAt);
        int  idx     = 0;
        int  firstC  = -1;
        bit  done    = 1'b0;
        bit  pokeNow = 1'b0;
        bit  poked   = 1'b0;
        @(posedge CLK); #1;
        iSeed  = DATA_W'(seed);
        iRatio = DATA_W'(ratio);
        iLast  = ADDR_W'(last);
        iStart = 1'b1;
        iReady = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge CLK); #1;
            iStart = 1'b0;
            if (pokeNow) begin
                iStart  = 1'b1;
                iSeed   = DATA_W'(999);
                iRatio  = '0;
                iLast   = ADDR_W'(1);
                pokeNow = 1'b0;
            end
            iReady = pat[c % 32];
            @(negedge CLK);
            if (c == 0) begin
                check({nm, " busy after start"}, longint'(oBusy), 1);
                check({nm, " sat cleared"}, longint'(oSat), 0);
            end
            if (oValid) begin
                if (firstC < 0) begin
                    firstC = c;
                    check({nm, " first valid latency"}, longint'(c + 1), 2);
                end
                check($sformatf("%s addr[%0d]", nm, idx), longint'(oAddr), longint'(idx));
                check($sformatf("%s data[%0d]", nm, idx), longint'(oData), longint'(expV[idx]));
                check($sformatf("%s sat[%0d]", nm, idx), longint'(oSat),
                      longint'(satFrom >= 0 && idx >= satFrom));
                check($sformatf("%s early done[%0d]", nm, idx), longint'(oDone), 0);
                check($sformatf("%s busy[%0d]", nm, idx), longint'(oBusy), 1);
                if (rstAt >= 0 && idx == rstAt) begin
                    #2 nRST = 1'b0;
                    #1 checkIdleOutputs({nm, " async"});
                    repeat (2) begin
                        @(negedge CLK);
                        check({nm, " no done in reset"}, longint'(oDone), 0);
                        check({nm, " no valid in reset"}, longint'(oValid), 0);
                    end
                    #2 nRST = 1'b1;
                    return;
                end
                if (poke && !poked && idx == 3) begin
                    pokeNow = 1'b1;
                    poked   = 1'b1;
                end
                if (iReady) idx++;
            end else if (firstC >= 0) begin
                check({nm, " done pulse"}, longint'(oDone), 1);
                check({nm, " entries accepted"}, longint'(idx), longint'(last + 1));
                done = 1'b1;
            end
        end
        if (!done) check({nm, " timeout"}, 0, 1);
        if (poke) begin
            iStart = 1'b1;
            iSeed  = DATA_W'(555);
            iLast  = ADDR_W'(3);
        end
        @(posedge CLK); #1;
        iStart = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check({nm, " idle valid"}, longint'(oValid), 0);
            check({nm, " idle busy"}, longint'(oBusy), 0);
            check({nm, " idle done"}, longint'(oDone), 0);
        end
        check({nm, " sticky sat"}, longint'(oSat), longint'(satFrom >= 0));
    endtask

    initial begin
        nRST   = 1'b0;
        iStart = 1'b0;
        iSeed  = '0;
        iRatio = '0;
        iLast  = '0;
        iReady = 1'b0;
        #1 checkIdleOutputs("reset");
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        expV = '{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096};
        runCase("unity", 4096, 4096, 7, '1, -1, 1'b0, -1);

        expV = '{4096, 2048, 1024, 512, 256, 128, 64, 32,
                 16, 8, 4, 2, 1, 1, 1, 1};
        runCase("half", 4096, 2048, 15, '1, -1, 1'b0, -1);

        expV = '{4096, 6144, 9216, 13824, 20736};
        runCase("stall", 4096, 6144, 4, 32'hAAAAAAA9, -1, 1'b0, -1);

        runCase("poke", 4096, 6144, 4, '1, -1, 1'b1, -1);

        expV = '{4096, 8192, 16384, 32768, 65536, 131072, 262143, 262143};
        runCase("double", 4096, 8192, 7, '1, 6, 1'b0, -1);

        expV = '{100, 200, 400};
        runCase("restart", 100, 8192, 2, '1, -1, 1'b0, -1);

        expV = '{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096};
        runCase("abort", 4096, 4096, 9, '1, -1, 1'b0, 5);

        expV = '{777};
        runCase("single", 777, 4096, 0, '1, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
